// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
package uart_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int BIT_RATE    = 9600;
    localparam int CLK_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int DATA_W      = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        SEND      = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: one-hot winner is the first set request
// found scanning upward from ptr, wrapping past NUM_REQ-1.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] win_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   rot_win;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign req_dbl = {req, req} >> ptr;
    assign rot     = req_dbl[NUM_REQ-1:0];
    assign rot_win = rot & (~rot + NUM_REQ'(1));
    assign win_dbl = {rot_win, rot_win} << ptr;
    assign winner  = win_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one uart_tx serializer.
// Define UART_TX_ARB_TIMEOUT_EN to force release of a stalled packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = uart_pkg::DATA_W,
    parameter int TIMEOUT_CLKS = 104160
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic [DATA_W-1:0]         tx_data_o,
    output logic                      tx_start_o,
    input  logic                      tx_done_i,
    output logic                      timeout_o
);
    import uart_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t                state_reg, state_next;
    logic [NUM_REQ-1:0]        grant_reg, grant_next;
    logic [PTR_W-1:0]          ptr_reg, ptr_next;
    logic                      last_reg, last_next;
    logic [DATA_W-1:0]         tx_data_reg, tx_data_next;
    logic                      tx_start_reg, tx_start_next;
    logic                      timeout_reg, timeout_next;

    logic [NUM_REQ-1:0]               pick;
    logic [NUM_REQ-1:0][DATA_W-1:0]   masked_data;
    logic [DATA_W-1:0]                granted_data;
    logic                             granted_last;
    logic [PTR_W-1:0]                 grant_idx;
    logic [PTR_W-1:0]                 ptr_adv;
    logic                             xfer;
    logic                             expire;

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (req_valid_i),
        .ptr    (ptr_reg),
        .winner (pick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_data[gi] = grant_reg[gi] ? req_data_i[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        granted_data = '0;
        grant_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            granted_data = granted_data | masked_data[i];
            if (grant_reg[i]) grant_idx = PTR_W'(i);
        end
    end

    assign granted_last = |(req_last_i & grant_reg);
    assign ptr_adv      = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
    assign req_ready_o  = (state_reg == WAIT_BYTE) ? grant_reg : '0;
    assign xfer         = |(req_valid_i & req_ready_o);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CLKS);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sent_reg, sent_next;

    // Only a packet that has already started can stall; the first byte may wait forever.
    assign expire = (state_reg == WAIT_BYTE) && sent_reg && !xfer &&
                    (cnt_reg == CNT_W'(TIMEOUT_CLKS-1));

    always_comb begin
        cnt_next  = '0;
        sent_next = sent_reg;
        if (state_reg == WAIT_BYTE && sent_reg && !xfer && !expire)
            cnt_next = cnt_reg + CNT_W'(1);
        if (xfer) sent_next = 1'b1;
        if (state_next == IDLE) sent_next = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_reg  <= '0;
            sent_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            sent_reg <= sent_next;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        last_next     = last_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = tx_start_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid_i) begin
                    grant_next = pick;
                    state_next = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (xfer) begin
                    tx_data_next  = granted_data;
                    last_next     = granted_last;
                    tx_start_next = 1'b1;
                    state_next    = SEND;
                end else if (expire) begin
                    grant_next   = '0;
                    ptr_next     = ptr_adv;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            SEND: begin
                if (tx_done_i) begin
                    tx_start_next = 1'b0;
                    if (last_reg) begin
                        grant_next = '0;
                        ptr_next   = ptr_adv;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_BYTE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            ptr_reg      <= '0;
            last_reg     <= 1'b0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            last_reg     <= last_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign grant_o    = grant_reg;
    assign busy_o     = (state_reg != IDLE);
    assign tx_data_o  = tx_data_reg;
    assign tx_start_o = tx_start_reg;
    assign timeout_o  = timeout_reg;

endmodule
